riscv_rsb_ckpt: RTL
===================

# riscv_rsb_ckpt

Parametrised return-stack buffer with checkpoint/restore for the RV12 pre-decode stage; successor to the fixed-depth RSB used for JAL/JALR return prediction. It keeps a circular stack of predicted return addresses and wraps around on overflow, overwriting the oldest entry. It performs push-and-pop in one cycle for coroutine-style JALR. It snapshots and restores its pointer state so a branch-unit or state flush recovers the stack as it was at a known-good instruction.

## Interface
- XLEN, 32, address width
- DEPTH, 4, number of stack entries; legal range 2..64; need not be a power of two
- HAS_RVC, 0, 0: pushed addresses masked with bits[1:0]=0; nonzero: only bit[0] cleared
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- ena_i  in  1  update enable; driven by the pre-decoder's "not stalled" signal
- push_i  in  1  push d_i (JAL/JALR with link rd)
- pop_i  in  1  pop top (JALR return through link rs1)
- d_i  in  XLEN  return address to push (PC + 2 or PC + 4)
- ckpt_i  in  1  capture checkpoint of pointer state
- restore_i  in  1  restore pointer state from checkpoint (pipeline flush)
- q_o  out  XLEN  current top-of-stack address; 0 when empty
- empty_o  out  1  count == 0
- full_o  out  1  count == DEPTH
- count_o  out  $clog2(DEPTH+1)  valid entries
- overflow_o  out  1  one-cycle pulse: push on full overwrote oldest entry
- underflow_o  out  1  one-cycle pulse: pop on empty was ignored

## Operation
- State: mem[0..DEPTH-1] (XLEN each), tos index (0..DEPTH-1), count (0..DEPTH), ckpt_tos, ckpt_cnt.
- Pointer arithmetic is modulo DEPTH. Increment from DEPTH-1 gives 0; decrement from 0 gives DEPTH-1.
- Pushed data = d_i & ADR_MASK (mask per HAS_RVC).
- Priority per cycle: rst_i > restore_i > ena_i-qualified push/pop/ckpt.
- restore_i: tos <= ckpt_tos, count <= ckpt_cnt. mem is untouched. Push/pop/ckpt in the same cycle are ignored, and so are their pulses. Applies regardless of ena_i.
- ena_i=0 with no restore: all state and the checkpoint hold; pulses are 0.
- With ena_i=1, the push_i/pop_i combinations behave as follows:
  - push only: tos <= tos+1; mem[tos+1] <= masked d_i. If count<DEPTH, count+1. Else count holds at DEPTH and overflow_o pulses (oldest entry lost).
  - pop only: if count>0, tos <= tos-1 and count-1. If count==0, no change and underflow_o pulses.
  - push and pop: mem[tos] <= masked d_i; tos and count unchanged. If count==0, it acts as push-only (count becomes 1, no underflow).
  - neither: hold.
- ckpt_i with ena_i=1: ckpt_tos/ckpt_cnt <= the post-update tos/count of the same cycle (including that cycle's push/pop).
- q_o = mem[tos] when count>0, else 0. Combinational from registered state only; no input-to-output combinational path.
- empty_o, full_o, count_o are decoded from registered count.
- Known limitation: restore recovers pointers only. Entries overwritten between checkpoint and restore are not recovered.

## Timing
- Reset (rst_i=1 at an edge): tos=0, count=0, ckpt_tos=0, ckpt_cnt=0, mem cleared to 0.
  - Outputs after reset: q_o=0, empty_o=1, full_o=0, count_o=0, overflow_o=0, underflow_o=0.
  - Reset asserted mid-sequence discards everything, including the checkpoint.
- Latency: push/pop/restore take effect one cycle later. q_o and count_o reflect them in the cycle after the edge.
- overflow_o and underflow_o are registered. They are high for exactly the one cycle following the offending edge.
- Back-to-back push/pop every cycle is supported with no bubbles.
- Simultaneous ckpt_i and restore_i: restore wins and the checkpoint is unchanged.

## Test plan
- Reset, then push 0x100, 0x204, 0x308 (DEPTH=4, HAS_RVC=0) → q_o=0x308, count_o=3. Pop → q_o=0x204, count_o=2.
- Push 5 values 0x10..0x50 at DEPTH=4 → overflow_o pulses once (5th push), full_o=1. Then pop 4 times → q_o sequence 0x40, 0x30, 0x20, then empty (q_o=0).
- Pop on empty → underflow_o=1 for one cycle, count_o stays 0. Push+pop on empty with d_i=0x123 → count_o=1, q_o=0x120 (HAS_RVC=0 mask).
- count=2 with top 0x200; push+pop with d_i=0x404 → q_o=0x404, count_o=2, tos unchanged. Hold ena_i=0 with push_i=1 → no change.
- Push 0xA0 with ckpt_i (checkpoint count=1), push 0xB0, pop, pop, then restore_i → count_o=1, q_o=0xA0. Restore with push_i=1 in the same cycle → push ignored.
- DEPTH=3, HAS_RVC=1: push 7 entries → tos wraps correctly, q_o=last pushed with bit0 cleared. Assert rst_i mid-stream → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/riscv_rsb_ckpt.sv
// Return-stack buffer for RV12 pre-decode: circular stack of predicted return
// addresses, with a single pointer checkpoint for flush recovery.
module riscv_rsb_ckpt #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int HAS_RVC = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ena_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [XLEN-1:0]            d_i,
  input  logic                       ckpt_i,
  input  logic                       restore_i,
  output logic [XLEN-1:0]            q_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] ADR_MASK = (HAS_RVC != 0) ? ~XLEN'(1) : ~XLEN'(3);
  localparam logic [TW-1:0]   TOS_LAST = TW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [TW-1:0]   tos, tos_nxt, ckpt_tos, ckpt_tos_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, ckpt_cnt, ckpt_cnt_nxt;
  logic            ovf_nxt, udf_nxt;
  logic            wr_en;
  logic [TW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_data;
  logic [TW-1:0]   tos_inc, tos_dec;

  // Modulo-DEPTH pointer steps; DEPTH need not be a power of two.
  assign tos_inc = (tos == TOS_LAST) ? '0 : tos + TW'(1);
  assign tos_dec = (tos == '0) ? TOS_LAST : tos - TW'(1);
  assign wr_data = d_i & ADR_MASK;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    tos_nxt      = tos;
    cnt_nxt      = cnt;
    ckpt_tos_nxt = ckpt_tos;
    ckpt_cnt_nxt = ckpt_cnt;
    wr_en        = 1'b0;
    wr_idx       = tos;
    ovf_nxt      = 1'b0;
    udf_nxt      = 1'b0;

    if (restore_i) begin
      tos_nxt = ckpt_tos;
      cnt_nxt = ckpt_cnt;
    end else if (ena_i) begin
      if (push_i && (!pop_i || cnt == '0)) begin
        // Push on empty with a simultaneous pop behaves as a plain push.
        tos_nxt = tos_inc;
        wr_en   = 1'b1;
        wr_idx  = tos_inc;
        if (cnt != CNT_FULL) cnt_nxt = cnt + CW'(1);
        else                 ovf_nxt = 1'b1;
      end else if (push_i && pop_i) begin
        wr_en  = 1'b1;
        wr_idx = tos;
      end else if (pop_i) begin
        if (cnt != '0) begin
          tos_nxt = tos_dec;
          cnt_nxt = cnt - CW'(1);
        end else begin
          udf_nxt = 1'b1;
        end
      end

      if (ckpt_i) begin
        ckpt_tos_nxt = tos_nxt;
        ckpt_cnt_nxt = cnt_nxt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos         <= '0;
      cnt         <= '0;
      ckpt_tos    <= '0;
      ckpt_cnt    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      // NOTE: the stack array is cleared on reset here because stale entries
      // must read back as zero; most RAM-style arrays are deliberately left
      // unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      tos         <= tos_nxt;
      cnt         <= cnt_nxt;
      ckpt_tos    <= ckpt_tos_nxt;
      ckpt_cnt    <= ckpt_cnt_nxt;
      overflow_o  <= ovf_nxt;
      underflow_o <= udf_nxt;
      if (wr_en) mem[wr_idx] <= wr_data;
    end
  end

  assign q_o     = (cnt != '0) ? mem[tos] : '0;
  assign count_o = cnt;
  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == CNT_FULL);

endmodule
